// File: rtl/demux_1x8_reg.sv
// Registered 1-to-8 demultiplexer with sticky per-channel "updated" flags.
// A write to a channel still holding unacknowledged data is back-pressured.
module demux_1x8_reg #(
   parameter int WIDTH = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [WIDTH-1:0]   din_i,
   input  logic [2:0]         sel_i,
   input  logic               en_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [7:0]         ack_i,
   output logic [7:0]         dec_o,
   output logic [8*WIDTH-1:0] q_o,
   output logic [7:0]         upd_o,
   output logic [3:0]         pend_cnt_o
);

   logic [8*WIDTH-1:0] data_q, data_d;
   logic [7:0]         upd_q, upd_d;
   logic [3:0]         pend_cnt_q, pend_cnt_d;
   logic               accept;

   // Acks clear flags first so a same-channel write re-sets its flag (write wins).
   always_comb begin
      dec_o      = en_i ? (8'b1 << sel_i) : 8'h00;
      in_ready_o = en_i & (~upd_q[sel_i] | ack_i[sel_i]);
      accept     = in_valid_i & in_ready_o;
      data_d     = data_q;
      upd_d      = upd_q & ~ack_i;
      if (accept) begin
         data_d[sel_i*WIDTH +: WIDTH] = din_i;
         upd_d[sel_i]                 = 1'b1;
      end
      pend_cnt_d = 4'd0;
      for (int i = 0; i < 8; i++) begin
         pend_cnt_d = pend_cnt_d + {3'b000, upd_d[i]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         data_q     <= '0;
         upd_q      <= 8'h00;
         pend_cnt_q <= 4'd0;
      end else begin
         data_q     <= data_d;
         upd_q      <= upd_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign q_o        = data_q;
   assign upd_o      = upd_q;
   assign pend_cnt_o = pend_cnt_q;

endmodule

// File: tb/tb_demux_1x8_reg.sv
// Directed self-checking bench for demux_1x8_reg; a small per-channel data
// model supplies expected register contents, flags and counts are hand-computed.
module tb_demux_1x8_reg;

   logic         clk = 1'b0;
   logic         reset;
   logic [15:0]  din;
   logic [2:0]   sel;
   logic         en;
   logic         inValid;
   logic         inReady;
   logic [7:0]   ack;
   logic [7:0]   dec;
   logic [127:0] q;
   logic [7:0]   upd;
   logic [3:0]   pendCnt;

   logic [15:0]  model [8];
   int           checkCount = 0;
   int           passCount  = 0;

   demux_1x8_reg #(.WIDTH(16)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .din_i      (din),
      .sel_i      (sel),
      .en_i       (en),
      .in_valid_i (inValid),
      .in_ready_o (inReady),
      .ack_i      (ack),
      .dec_o      (dec),
      .q_o        (q),
      .upd_o      (upd),
      .pend_cnt_o (pendCnt)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] packModel();
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[i*16 +: 16] = model[i];
      return v;
   endfunction

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   task automatic checkState(input string tag, input logic [7:0] expUpd, input logic [3:0] expPend);
      checkOutput({tag, "_q"}, q, packModel());
      checkOutput({tag, "_upd"}, {120'd0, upd}, {120'd0, expUpd});
      checkOutput({tag, "_pend"}, {124'd0, pendCnt}, {124'd0, expPend});
      checkOutput({tag, "_pend_range"}, {127'd0, (pendCnt <= 4'd8)}, 128'd1);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      reset = 1'b1; din = 16'h0000; sel = 3'd0; en = 1'b0; inValid = 1'b0; ack = 8'h00;
      #1;
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      applyStimulus();

      // Reset then idle
      checkState("reset", 8'h00, 4'd0);
      en = 1'b1; sel = 3'd0;
      #1;
      checkOutput("idle_ready", {127'd0, inReady}, 128'd1);
      checkOutput("idle_dec", {120'd0, dec}, {120'd0, 8'h01});

      // Write and hold
      sel = 3'd5; din = 16'hBEEF; inValid = 1'b1;
      #1;
      checkOutput("wr5_dec", {120'd0, dec}, {120'd0, 8'h20});
      checkOutput("wr5_ready", {127'd0, inReady}, 128'd1);
      applyStimulus();
      inValid = 1'b0;
      model[5] = 16'hBEEF;
      checkState("wr5", 8'h20, 4'd1);

      // Backpressure, then same-cycle ack lets the write through
      sel = 3'd5; din = 16'h1234; inValid = 1'b1; ack = 8'h00;
      #1;
      checkOutput("bp_ready", {127'd0, inReady}, 128'd0);
      applyStimulus();
      checkState("bp_hold", 8'h20, 4'd1);
      ack = 8'h20;
      #1;
      checkOutput("bp_ack_ready", {127'd0, inReady}, 128'd1);
      applyStimulus();
      inValid = 1'b0; ack = 8'h00;
      model[5] = 16'h1234;
      checkState("bp_wr", 8'h20, 4'd1);

      // Fill all channels; channel 5 is still full so it is acked while rewritten
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s); din = 16'h0100 + 16'(s); inValid = 1'b1;
         ack = (s == 5) ? 8'h20 : 8'h00;
         #1;
         checkOutput($sformatf("fill_ready%0d", s), {127'd0, inReady}, 128'd1);
         applyStimulus();
         model[s] = 16'h0100 + 16'(s);
      end
      inValid = 1'b0; ack = 8'h00;
      checkState("full", 8'hFF, 4'd8);
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         #1;
         checkOutput($sformatf("full_ready%0d", s), {127'd0, inReady}, 128'd0);
      end
      ack = 8'hFF;
      applyStimulus();
      ack = 8'h00;
      checkState("ack_all", 8'h00, 4'd0);

      // Enable gating
      en = 1'b0; inValid = 1'b1; sel = 3'd3; din = 16'hAAAA;
      #1;
      checkOutput("gate_dec", {120'd0, dec}, 128'd0);
      checkOutput("gate_ready", {127'd0, inReady}, 128'd0);
      applyStimulus();
      checkState("gate", 8'h00, 4'd0);
      inValid = 1'b0; en = 1'b1; ack = 8'h08;
      applyStimulus();
      ack = 8'h00;
      checkState("ack_empty", 8'h00, 4'd0);

      // Build upd=0F, including an accept on one channel with an ack on another
      inValid = 1'b1;
      for (int s = 0; s < 3; s++) begin
         sel = 3'(s); din = 16'hC000 + 16'(s);
         applyStimulus();
         model[s] = 16'hC000 + 16'(s);
      end
      sel = 3'd3; din = 16'hC003; ack = 8'h01;
      applyStimulus();
      model[3] = 16'hC003;
      ack = 8'h00;
      checkState("wr_ack_other", 8'h0E, 4'd3);
      sel = 3'd0; din = 16'hD000;
      applyStimulus();
      model[0] = 16'hD000;
      inValid = 1'b0;
      checkState("pre_reset", 8'h0F, 4'd4);

      // Reset overrides a concurrent accept and ack
      reset = 1'b1; inValid = 1'b1; sel = 3'd6; din = 16'h5555; ack = 8'h01;
      applyStimulus();
      reset = 1'b0; inValid = 1'b0; ack = 8'h00;
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      checkState("mid_reset", 8'h00, 4'd0);
      #1;
      checkOutput("post_reset_ready", {127'd0, inReady}, 128'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/demux_1x8_reg.md
Name: demux_1x8_reg

Overview:
Registered 1-to-8 demultiplexer. It routes a WIDTH-bit word to one of eight holding registers selected by a 3-bit select, and is the distribution counterpart of the 8x1 selection path. Each channel carries a sticky "updated" flag that the consumer clears with a per-channel acknowledge. A write to a channel that has not been acknowledged is back-pressured, so no data is lost. It sits between the datapath result bus and eight downstream consumers, such as register write-back lanes or peripheral ports.

Parameters:
WIDTH, 16, data width of the input word and of each channel register

Ports:
clk       input   1          rising-edge clock
reset     input   1          synchronous, active-high reset
din       input   WIDTH      word to distribute
sel       input   3          destination channel, s2:s1:s0, 0..7
en        input   1          enable; when 0, nothing is accepted and dec is 0
in_valid  input   1          din/sel are valid this cycle
in_ready  output  1          block can accept this cycle (combinational)
ack       input   8          per-channel acknowledge; clears upd[i]
dec       output  8          combinational one-hot decode of sel, gated by en
q         output  8*WIDTH    channel registers; channel i at q[i*WIDTH +: WIDTH]
upd       output  8          sticky per-channel "new data" flags
pend_cnt  output  4          number of set upd bits, 0..8, registered

Behaviour:
- Reset, synchronous, at a clk edge with reset=1:
  - all q = 0, upd = 8'h00, pend_cnt = 0.
  - Reset overrides any accept or ack in the same cycle.
  - A transfer in flight when reset is asserted is discarded.
- dec = en ? (8'b1 << sel) : 8'h00. Purely combinational, independent of in_valid.
- in_ready = en & (~upd[sel] | ack[sel]).
  - A channel holding unacknowledged data blocks a new write unless it is acked in the same cycle.
- accept = in_valid & in_ready.
- On accept at a clk edge:
  - q channel sel <= din.
  - upd[sel] <= 1.
  - Latency is one cycle: the new value is visible on q the cycle after acceptance.
  - All other channels hold their values.
- Ack handling:
  - ack[i]=1 with upd[i]=1: upd[i] <= 0 at the edge. The q value is retained; acknowledge never clears data.
  - ack[i]=1 with upd[i]=0: no effect.
- Simultaneous accept and ack on the same channel: the write wins. q is updated, upd stays 1, and pend_cnt is unchanged.
- Simultaneous accept on channel a and ack on channel b (a != b): both take effect in the same edge.
- Multiple ack bits may be set at once; each is handled independently.
- pend_cnt is registered and always equals popcount(upd) after each edge.
  - Next value = pend_cnt + (accept & ~upd[sel]) − (number of acked bits that are currently set, excluding channel sel when accepting).
  - Range 0..8; no wrap. This is guaranteed by construction and asserted in the bench.
- en=0 or in_valid=0: no writes occur. Acks are still processed.
- sel changes while in_valid=0: no effect on state.
- No internal FSM beyond the per-channel flag; each channel is a two-state machine, EMPTY (upd=0) and FULL (upd=1):
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on ack without a concurrent accept.
  - FULL -> FULL on accept+ack.

Test Plan:
1. Reset then idle
   - Stimulus: reset=1 for 2 cycles, then 0, no inputs.
   - Response: q all 0, upd=00, pend_cnt=0, in_ready=1 with en=1, dec=8'h01 for sel=0.
2. Write and hold
   - Stimulus: en=1, in_valid=1, sel=5, din=16'hBEEF for one cycle.
   - Response: next cycle q[5]=BEEF, upd=8'h20, pend_cnt=1; other channels 0.
3. Backpressure
   - Stimulus: with upd[5]=1, present sel=5, din=16'h1234, ack=0.
   - Response: in_ready=0 and q[5] stays BEEF.
   - Then raise ack[5] in the same cycle: in_ready=1; next cycle q[5]=1234, upd[5]=1, pend_cnt=1.
4. Fill all channels
   - Stimulus: write sel=0..7 with din=16'h0100+sel on consecutive cycles.
   - Response: upd=FF, pend_cnt=8, in_ready=0 for every sel.
   - Then ack=FF for one cycle: upd=00, pend_cnt=0, q values retained.
5. Enable gating
   - Stimulus: en=0, in_valid=1, sel=3.
   - Response: dec=00, in_ready=0, no state change.
   - Stimulus: ack[3] on an empty channel.
   - Response: no change.
6. Reset mid-operation
   - Stimulus: upd=8'h0F, then reset=1 in the same cycle as an accept to sel=6 and ack=8'h01.
   - Response: next cycle q all 0, upd=00, pend_cnt=0.
